fft16_radix4_ctrl: RTL and testbench

//  Sequences an in-place 16-point radix-4 DIT FFT over an external 16-entry

---
 rtl/fft16_radix4_ctrl.sv | 159 +++++++++++++++
 tb/tb_fft16_radix4_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_radix4_ctrl.sv
// In-place 16-point radix-4 DIT FFT sequencer: walks 2 stages x 4 butterflies over an
// external sync RAM, feeding one shared combinational butterfly and writing results back.
module fft16_radix4_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_we,
  output logic [3:0]       mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_c,
  output logic [WIDTH-1:0] bf_d,
  output logic [3:0]       tw_k1,
  output logic [3:0]       tw_k2,
  output logic [3:0]       tw_k3,
  input  logic [WIDTH-1:0] bf_out0,
  input  logic [WIDTH-1:0] bf_out1,
  input  logic [WIDTH-1:0] bf_out2,
  input  logic [WIDTH-1:0] bf_out3,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RLAST = 3'd2,
    S_CALC  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       cnt, cnt_nx;
  logic [1:0]       bfly, bfly_nx;
  logic             stage, stage_nx;
  logic [3:0]       addr;
  logic [3:0]       j4, tw1_nx, tw2_nx, tw3_nx;
  logic [WIDTH-1:0] res [4];

  // Handshake: start is a request sampled only in IDLE; while busy (or in the DONE
  // cycle) start is dropped, so the requester must hold or re-pulse it once idle.

  // Stage 0 groups adjacent samples (4g+n), stage 1 strides by 4 (j+4n).
  assign addr = stage ? {cnt, bfly} : {bfly, cnt};

  assign j4     = {2'b00, bfly};
  assign tw1_nx = stage ? j4 : 4'd0;
  assign tw2_nx = stage ? (j4 << 1) : 4'd0;
  assign tw3_nx = stage ? (j4 + (j4 << 1)) : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      bfly  <= 2'd0;
      stage <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bfly  <= bfly_nx;
      stage <= stage_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bfly_nx  = bfly;
    stage_nx = stage;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD;
          cnt_nx   = 2'd0;
          bfly_nx  = 2'd0;
          stage_nx = 1'b0;
        end
      end
      S_RD: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) state_nx = S_RLAST;
      end
      S_RLAST: state_nx = S_CALC;
      S_CALC: begin
        state_nx = S_WR;
        cnt_nx   = 2'd0;
      end
      S_WR: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          bfly_nx  = bfly + 2'd1;
          state_nx = S_RD;
          if (bfly == 2'd3) begin
            stage_nx = ~stage;
            if (stage) state_nx = S_DONE;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    mem_raddr = (state == S_RD) ? addr : 4'd0;
    mem_we    = (state == S_WR);
    mem_waddr = (state == S_WR) ? addr : 4'd0;
    mem_wdata = (state == S_WR) ? res[cnt] : '0;
    dbg_state = state;
  end

  // RAM read latency is one cycle, so the sample addressed in RD cnt n lands at cnt n+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_a  <= '0;
      bf_b  <= '0;
      bf_c  <= '0;
      bf_d  <= '0;
      tw_k1 <= 4'd0;
      tw_k2 <= 4'd0;
      tw_k3 <= 4'd0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      case (state)
        S_RD: begin
          case (cnt)
            2'd1:    bf_a <= mem_rdata;
            2'd2:    bf_b <= mem_rdata;
            2'd3:    bf_c <= mem_rdata;
            default: ;
          endcase
        end
        S_RLAST: begin
          bf_d  <= mem_rdata;
          tw_k1 <= tw1_nx;
          tw_k2 <= tw2_nx;
          tw_k3 <= tw3_nx;
        end
        S_CALC: begin
          res[0] <= bf_out0;
          res[1] <= bf_out1;
          res[2] <= bf_out2;
          res[3] <= bf_out3;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_radix4_ctrl.sv
// Bench for fft16_radix4_ctrl: sync RAM model, radix-4 butterfly and W16 twiddle ROM
// around the sequencer, with directed transforms checked against hand-computed results.
module tb_fft16_radix4_ctrl;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, done, mem_we;
  logic [3:0]   mem_raddr, mem_waddr;
  logic [W-1:0] mem_rdata, mem_wdata;
  logic [W-1:0] bf_a, bf_b, bf_c, bf_d;
  logic [3:0]   tw_k1, tw_k2, tw_k3;
  logic [W-1:0] bf_out0, bf_out1, bf_out2, bf_out3;
  logic [2:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mem [16];
  logic [W-1:0] img [16];
  logic         ld_we = 1'b0;
  logic [3:0]   ld_addr = 4'd0;
  logic [W-1:0] ld_data = '0;
  logic [3:0]   exp_q [$];

  fft16_radix4_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .bf_a(bf_a), .bf_b(bf_b), .bf_c(bf_c), .bf_d(bf_d),
    .tw_k1(tw_k1), .tw_k2(tw_k2), .tw_k3(tw_k3),
    .bf_out0(bf_out0), .bf_out1(bf_out1), .bf_out2(bf_out2), .bf_out3(bf_out3),
    .dbg_state(dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_waddr] <= mem_wdata;
    else if (ld_we) mem[ld_addr]   <= ld_data;
    mem_rdata <= mem[mem_raddr];
  end

  // twiddle ROM {re13, im13}, 1.0 = 2048
  function automatic int cosv(input int k);
    case (k % 16)
      0: return 2048;   1: return 1892;   2: return 1448;   3: return 784;
      4: return 0;      5: return -784;   6: return -1448;  7: return -1892;
      8: return -2048;  9: return -1892;  10: return -1448; 11: return -784;
      12: return 0;     13: return 784;   14: return 1448;  default: return 1892;
    endcase
  endfunction

  function automatic logic [25:0] tw_rom(input int k);
    return {13'(cosv(k)), 13'(-cosv(k + 12))};
  endfunction

  function automatic logic [23:0] cmul(input logic [23:0] x, input logic [25:0] w);
    logic signed [25:0] xr, xi, wr, wi, pr, pi;
    xr = $signed(x[23:12]);
    xi = $signed(x[11:0]);
    wr = $signed(w[25:13]);
    wi = $signed(w[12:0]);
    pr = xr * wr - xi * wi;
    pi = xr * wi + xi * wr;
    return {pr[22:11], pi[22:11]};
  endfunction

  function automatic logic [23:0] pack(input int re, input int im);
    return {re[11:0], im[11:0]};
  endfunction

  logic [23:0] bp, cp, dp;
  logic [11:0] ar, ai, br, bi, cr, ci, dr, di;
  always_comb begin
    bp = cmul(bf_b, tw_rom(int'(tw_k1)));
    cp = cmul(bf_c, tw_rom(int'(tw_k2)));
    dp = cmul(bf_d, tw_rom(int'(tw_k3)));
    ar = bf_a[23:12]; ai = bf_a[11:0];
    br = bp[23:12];   bi = bp[11:0];
    cr = cp[23:12];   ci = cp[11:0];
    dr = dp[23:12];   di = dp[11:0];
    bf_out0 = {ar + br + cr + dr, ai + bi + ci + di};
    bf_out1 = {ar + bi - cr - di, ai - br - ci + dr};
    bf_out2 = {ar - br + cr - dr, ai - bi + ci - di};
    bf_out3 = {ar - bi - cr + di, ai + br - ci - dr};
  end

  // driver tasks
  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      ld_we   = 1'b1;
      ld_addr = 4'(i);
      ld_data = img[i];
      @(posedge clk); #1;
    end
    ld_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_run(input int again, output int done_at, output int done_cnt,
                        output int we_after, output int busy_after,
                        output logic b0, output logic b79, output logic b80);
    done_at = -1; done_cnt = 0; we_after = 0; busy_after = 0;
    b0 = 1'b0; b79 = 1'b0; b80 = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      start = (cyc == again);
      if (cyc == 0)  b0  = busy;
      if (cyc == 79) b79 = busy;
      if (cyc == 80) b80 = busy;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end else if (done_at >= 0) begin
        if (mem_we) we_after++;
        if (busy)   busy_after++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, mem_we});
    end
    checks++;
    if ({mem_raddr, mem_waddr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem: got %h expected 0", {mem_raddr, mem_waddr, mem_wdata});
    end
    checks++;
    if ({bf_a, bf_b, bf_c, bf_d, tw_k1, tw_k2, tw_k3} !== '0) begin
      errors++; $display("FAIL reset_bf: got %h expected 0", {bf_a, bf_b, bf_c, bf_d, tw_k1, tw_k2, tw_k3});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_impulse();
    int da, dc, wa, ba; logic b0, b79, b80;
    for (int i = 0; i < 16; i++) img[i] = (i == 0) ? pack(100, 0) : '0;
    load_img();
    do_run(-1, da, dc, wa, ba, b0, b79, b80);
    checks++;
    if (da !== 80) begin errors++; $display("FAIL impulse_done_at: got %0d expected 80", da); end
    checks++;
    if ({b0, b79, b80} !== 3'b110) begin
      errors++; $display("FAIL impulse_busy: got %b expected 110", {b0, b79, b80});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== pack(100, 0)) begin
        errors++; $display("FAIL impulse_mem[%0d]: got %h expected %h", i, mem[i], pack(100, 0));
      end
    end
  endtask

  task automatic test_dc();
    int da, dc, wa, ba; logic b0, b79, b80;
    for (int i = 0; i < 16; i++) img[i] = pack(10, 0);
    load_img();
    do_run(80, da, dc, wa, ba, b0, b79, b80);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL dc_done_count: got %0d expected 1", dc); end
    checks++;
    if (ba !== 0) begin errors++; $display("FAIL dc_start_in_done: got busy cycles %0d expected 0", ba); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ((i == 0) ? pack(160, 0) : 24'h0)) begin
        errors++; $display("FAIL dc_mem[%0d]: got %h expected %h", i, mem[i], (i == 0) ? pack(160, 0) : 24'h0);
      end
    end
  endtask

  task automatic test_twiddle();
    int da, dc, wa, ba; logic b0, b79, b80;
    logic [23:0] exp_v [16];
    for (int i = 0; i < 16; i++) img[i] = (i == 4) ? pack(100, 0) : '0;
    load_img();
    do_run(-1, da, dc, wa, ba, b0, b79, b80);
    exp_v[0]  = pack(100, 0);  exp_v[4]  = pack(0, -100);
    exp_v[8]  = pack(-100, 0); exp_v[12] = pack(0, 100);
    exp_v[1]  = pack(92, -39); exp_v[5]  = pack(-39, -92);
    exp_v[9]  = pack(-92, 39); exp_v[13] = pack(39, 92);
    exp_v[2]  = pack(70, -71); exp_v[3]  = pack(38, -93);
    foreach (exp_v[i]) begin
      if (i inside {0, 1, 2, 3, 4, 5, 8, 9, 12, 13}) begin
        checks++;
        if (mem[i] !== exp_v[i]) begin
          errors++; $display("FAIL twiddle_mem[%0d]: got %h expected %h", i, mem[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_trace();
    logic [3:0] e;
    for (int i = 0; i < 16; i++) img[i] = 24'($urandom_range(1, 24'hFFFFFF));
    load_img();
    exp_q.delete();
    foreach (img[i]) if (i % 4 == 2) exp_q.push_back(4'(i));
    foreach (img[i]) if (i % 4 == 2) exp_q.push_back(4'(i));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 82; cyc++) begin
      if (cyc >= 60 && cyc <= 63) begin
        e = exp_q.pop_front();
        checks++;
        if (mem_raddr !== e) begin
          errors++; $display("FAIL trace_raddr@%0d: got %0d expected %0d", cyc, mem_raddr, e);
        end
      end
      if (cyc == 65) begin
        checks++;
        if ({tw_k1, tw_k2, tw_k3} !== {4'd2, 4'd4, 4'd6}) begin
          errors++; $display("FAIL trace_tw: got %0d,%0d,%0d expected 2,4,6", tw_k1, tw_k2, tw_k3);
        end
      end
      if (cyc == 64 || cyc == 65) begin
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL trace_we_idle@%0d: got 1 expected 0", cyc); end
      end
      if (cyc >= 66 && cyc <= 69) begin
        e = exp_q.pop_front();
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== e) begin
          errors++; $display("FAIL trace_write@%0d: got we=%b addr=%0d expected we=1 addr=%0d", cyc, mem_we, mem_waddr, e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy();
    int da, dc, wa, ba; logic b0, b79, b80;
    for (int i = 0; i < 16; i++) img[i] = (i == 0) ? pack(100, 0) : '0;
    load_img();
    do_run(20, da, dc, wa, ba, b0, b79, b80);
    checks++;
    if (da !== 80 || dc !== 1) begin
      errors++; $display("FAIL busy_start_done: got at=%0d count=%0d expected at=80 count=1", da, dc);
    end
    checks++;
    if (wa !== 0) begin errors++; $display("FAIL busy_start_writes: got %0d expected 0", wa); end
    checks++;
    if (mem[5] !== pack(100, 0)) begin
      errors++; $display("FAIL busy_start_mem5: got %h expected %h", mem[5], pack(100, 0));
    end
  endtask

  task automatic test_mid_reset();
    int da, dc, wa, ba, nd; logic b0, b79, b80;
    for (int i = 0; i < 16; i++) img[i] = 24'($urandom_range(1, 24'hFFFFFF));
    load_img();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_we, mem_raddr, mem_waddr, mem_wdata} !== '0) begin
      errors++; $display("FAIL midrst_ctrl: got %h expected 0", {busy, done, mem_we, mem_raddr, mem_waddr, mem_wdata});
    end
    checks++;
    if ({bf_a, bf_b, bf_c, bf_d, tw_k1, tw_k2, tw_k3} !== '0) begin
      errors++; $display("FAIL midrst_bf: got %h expected 0", {bf_a, bf_b, bf_c, bf_d, tw_k1, tw_k2, tw_k3});
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (done || busy || mem_we) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", nd); end
    for (int i = 0; i < 16; i++) img[i] = (i == 0) ? pack(100, 0) : '0;
    load_img();
    do_run(-1, da, dc, wa, ba, b0, b79, b80);
    checks++;
    if (da !== 80) begin errors++; $display("FAIL midrst_restart_done: got %0d expected 80", da); end
    for (int i = 0; i < 16; i += 5) begin
      checks++;
      if (mem[i] !== pack(100, 0)) begin
        errors++; $display("FAIL midrst_mem[%0d]: got %h expected %h", i, mem[i], pack(100, 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_twiddle();
    test_trace();
    test_start_while_busy();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
